// File: rtl/maxfind_pkg.sv
// Shared FSM state type and default widths for the sequential max finder.
package maxfind_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/maxfind_dp.sv
// Max/index registers, beat counter and comparator; MAXFIND_SIGNED_EN selects a signed compare.
// Registers update on the edge after their strobe; no flow control of its own, the FSM gates every beat.
module maxfind_dp
  import maxfind_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              inc,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] max_val,
  output logic [LEN_W-1:0]  max_idx,
  output logic              gtr,
  output logic              first,
  output logic              last
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;

  // The counter stops at len after the last beat, so len = 2^LEN_W-1 never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else if (clear) begin
      len_q   <= len;
      cnt_q   <= '0;
      max_val <= '0;
      max_idx <= '0;
    end else begin
      if (load) begin
        max_val <= in_data;
        max_idx <= cnt_q;
      end
      if (inc) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

`ifdef MAXFIND_SIGNED_EN
  assign gtr = $signed(in_data) > $signed(max_val);
`else
  assign gtr = in_data > max_val;
`endif

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == len_q - LEN_W'(1));

endmodule

// File: rtl/maxfind_seq.sv
// Sequential max search over len streamed samples; MAXFIND_SIGNED_EN makes the compare signed.
// done pulses the cycle after the last beat; in_ready only in SCAN, which waits indefinitely on in_valid.
module maxfind_seq
  import maxfind_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] max_val,
  output logic [LEN_W-1:0]  max_idx,
  output logic              busy,
  output logic              done
);

  state_t state_q;
  state_t state_d;
  logic   clear;
  logic   beat;
  logic   load;
  logic   gtr;
  logic   first;
  logic   last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (len == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN: if (beat && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy  = 1'b0;
        clear = start;
      end
      ST_SCAN: in_ready = 1'b1;
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign beat = in_valid && in_ready;
  // Beat 0 always seeds the max so a negative first sample wins in the signed build.
  assign load = beat && (first || gtr);

  maxfind_dp #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .load    (load),
    .inc     (beat),
    .len     (len),
    .in_data (in_data),
    .max_val (max_val),
    .max_idx (max_idx),
    .gtr     (gtr),
    .first   (first),
    .last    (last)
  );

endmodule

// File: tb/tb_maxfind_seq.sv
// Bench for maxfind_seq: directed and random searches scored against a max-then-first-index model.
module tb_maxfind_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] max_val;
  logic [7:0] max_idx;
  logic       busy;
  logic       done;

  int         total  = 0;
  int         passed = 0;
  logic [7:0] smp[$];

  always #5 clk = ~clk;

  maxfind_seq #(
    .DATA_W (8),
    .LEN_W  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .max_val  (max_val),
    .max_idx  (max_idx),
    .busy     (busy),
    .done     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit gt(input logic [7:0] a, input logic [7:0] b);
`ifdef MAXFIND_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Drives one full search of n samples from smp, then checks result and hold.
  task automatic run_search(input int n, input int gap, input bit rand_gap, input bit poke);
    logic [7:0] em;
    int         ei;
    int         early;
    int         rdy_bad;
    int         g;
    em = 8'd0; ei = 0; early = 0; rdy_bad = 0;
    if (n > 0) begin
      em = smp[0];
      for (int i = 1; i < n; i++) if (gt(smp[i], em)) em = smp[i];
      for (int i = n - 1; i >= 0; i--) if (smp[i] == em) ei = i;
    end
    start = 1'b1;
    len   = n[7:0];
    step();
    start = 1'b0;
    if (n == 0) begin
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_ready", 32'(in_ready), 32'd0);
    end else begin
      chk("scan_busy", 32'(busy), 32'd1);
      for (int b = 0; b < n; b++) begin
        g = rand_gap ? int'($urandom_range(0, 2)) : gap;
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          start    = poke;
          if (in_ready !== 1'b1) rdy_bad++;
          step();
          if (done !== 1'b0) early++;
        end
        start    = poke;
        in_valid = 1'b1;
        in_data  = smp[b];
        if (in_ready !== 1'b1) rdy_bad++;
        step();
        if (b < n - 1 && done !== 1'b0) early++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("no_early_done", 32'(early), 32'd0);
      chk("ready_in_scan", 32'(rdy_bad), 32'd0);
      chk("done_pulse", 32'(done), 32'd1);
    end
    step();
    chk("done_cleared", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("max_val", 32'(max_val), 32'(em));
    chk("max_idx", 32'(max_idx), 32'(ei));
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    in_valid = 1'b0;
    chk("hold_val", 32'(max_val), 32'(em));
    chk("hold_idx", 32'(max_idx), 32'(ei));
  endtask

  initial begin
    int n;
    int dcount;
    rst = 1'b1; start = 1'b1; len = 8'd3; in_valid = 1'b1; in_data = 8'h77;
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_val", 32'(max_val), 32'd0);
    chk("rst_idx", 32'(max_idx), 32'd0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    step();
    chk("idle_after_rst", 32'(busy), 32'd0);

    smp = '{8'd3, 8'd9, 8'd2, 8'd7};
    run_search(4, 0, 1'b0, 1'b0);
    smp = '{8'd5, 8'd5, 8'd5};
    run_search(3, 0, 1'b0, 1'b0);
    smp.delete();
    run_search(0, 0, 1'b0, 1'b0);
    smp = '{8'd4, 8'd1, 8'd6};
    run_search(3, 2, 1'b0, 1'b1);
    smp = '{8'hFF, 8'h01};
    run_search(2, 0, 1'b0, 1'b0);

    // Abort after two of four beats; the beat and start in the reset cycle must be dropped.
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h20;
    step();
    in_data = 8'h30;
    step();
    rst = 1'b1; start = 1'b1; in_data = 8'h40;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_val", 32'(max_val), 32'd0);
    chk("abort_idx", 32'(max_idx), 32'd0);
    dcount = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) dcount++;
    end
    chk("abort_quiet", 32'(dcount), 32'd0);
    smp = '{8'd2, 8'd8};
    run_search(2, 0, 1'b0, 1'b0);

    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    chk("pre_rst_done", 32'(done), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_in_done", 32'(done), 32'd0);
    chk("rst_in_done_val", 32'(max_val), 32'd0);
    step();

    for (int t = 0; t < 10; t++) begin
      n = int'($urandom_range(1, 12));
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(8'($urandom));
      run_search(n, 0, 1'b1, 1'($urandom_range(0, 1)));
    end

    smp.delete();
    for (int i = 0; i < 255; i++) smp.push_back(8'($urandom));
    run_search(255, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/maxfind_seq.md
MAXFIND_SEQ -- requirements
Module: maxfind_seq

Interface
REQ-001 Parameter DATA_W, default 8: width of each sample and of max_val.
REQ-002 Parameter LEN_W, default 8: width of len and max_idx.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request a new max search; sampled only in IDLE.
REQ-006 Port len, input, LEN_W: number of samples in the search; latched when start is accepted.
REQ-007 Port in_valid, input, 1: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-009 Port in_data, input, DATA_W: sample value.
REQ-010 Port max_val, output, DATA_W: largest sample in the current or last search.
REQ-011 Port max_idx, output, LEN_W: 0-based beat index of max_val.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: one-cycle pulse marking the end of a search.

Function
REQ-014 FSM states: IDLE, SCAN, DONE; encoding defined in the package.
REQ-015 IDLE with start=1: the FSM latches len, clears max_val, max_idx and beat counter to 0, and goes to SCAN if len!=0 or DONE if len==0.
REQ-016 In IDLE with start=0, the FSM stays in IDLE.
REQ-017 in_ready is 1 only in SCAN; a beat is in_valid && in_ready.
REQ-018 Beat 0 loads max_val=in_data and max_idx=0 unconditionally.
REQ-019 Beat k>0 loads max_val=in_data and max_idx=k only if in_data > max_val (strict); ties keep the earlier index.
REQ-020 The beat counter increments per beat; the beat with counter == len-1 is the last beat and moves the FSM to DONE.
REQ-021 SCAN with in_valid=0 holds all state with no timeout.
REQ-022 DONE lasts exactly one cycle with done=1, then goes to IDLE.
REQ-023 start is ignored in SCAN and DONE; a new search needs start in IDLE.
REQ-024 max_val and max_idx hold after DONE until the next accepted start.
REQ-025 Latency: start accepted at cycle 0 with back-to-back beats at cycles 1..N gives done=1 at cycle N+1.
REQ-026 len == 2^LEN_W-1 completes without counter wrap; max_idx never exceeds len-1.
REQ-027 len=0 gives done one cycle after start, with max_val=0 and max_idx=0, and no beats are accepted.

Reset
REQ-028 rst=1 at a clock edge forces IDLE: in_ready=0, busy=0, done=0, max_val=0, max_idx=0, counter=0.
REQ-029 Reset during SCAN or DONE aborts the search; no done pulse is produced, and a beat presented in the reset cycle is not accepted.
REQ-030 rst takes priority over start and in_valid in the same cycle.

Configuration
REQ-031 Macro MAXFIND_SIGNED_EN defined: the comparison in REQ-019 is two's-complement signed over DATA_W bits.
REQ-032 MAXFIND_SIGNED_EN undefined: the comparison is unsigned; port list and timing are identical in both builds.

Structure
REQ-033 Package maxfind_pkg SHALL hold the state enum typedef and the default DATA_W and LEN_W constants.
REQ-034 maxfind_seq SHALL instantiate the sub-module maxfind_dp, which holds the max register, index register, beat counter and comparator.
REQ-035 maxfind_dp SHALL take load/clear/increment controls from the FSM and return gtr (the greater-than flag) and last.

Verification
REQ-036 len=4, samples 3,9,2,7, continuous in_valid -> done at cycle 5, max_val=9, max_idx=1.
REQ-037 len=3, samples 5,5,5 -> max_val=5, max_idx=0 (tie keeps earliest).
REQ-038 len=0 -> done one cycle after start, max_val=0, max_idx=0, in_ready never 1.
REQ-039 len=3 with in_valid gaps of 2 cycles between beats -> result correct; done one cycle after the last beat; start pulses during SCAN ignored.
REQ-040 rst asserted after 2 of 4 beats -> next cycle IDLE, all outputs 0, no done; a fresh search of 2,8 gives max_val=8, max_idx=1.
REQ-041 With MAXFIND_SIGNED_EN, DATA_W=8, samples 8'hFF, 8'h01 -> max_val=8'h01, max_idx=1; without the macro -> max_val=8'hFF, max_idx=0.
